// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-subset core: control FSM, register file, ALU and a single
// req/ack memory port shared by instruction fetch and data access.
//
// state  | meaning
// FETCH  | issue / await instruction read, IR <= rdata, PC += 4
// DECODE | latch A/B from register file, check opcode/funct
// EXEC   | ALU op, address calc, branch / jump resolution
// MEM    | issue / await lw read or sw write
// WB     | write ALUOut or MDR to rd / rt
// ERR    | undecodable instruction, parked until reset
module mc_cpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input  logic        clk,
    input  logic        cpu_rst_n,
    input  logic        cpu_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    input  logic [4:0]  debug_addr,
    output logic [31:0] debug_data,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instr_count
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

    state_t      st;
    logic [31:0] ir, a, b, alu_out, mdr;
    logic [31:0] rf [0:31];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] sext, zext, alu_res, wb_data;
    logic [4:0]  wb_dst;
    logic        legal, taken;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];
    assign target = ir[25:0];
    assign sext   = {{16{imm[15]}}, imm};
    assign zext   = {16'h0000, imm};

    assign state      = st;
    assign debug_data = (debug_addr == 5'd0) ? 32'h0 : rf[debug_addr];

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R: case (funct)
                6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02: legal = 1'b1;
                default: legal = 1'b0;
            endcase
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = 32'h0;
        if (opcode == OP_R) begin
            case (funct)
                6'h20:   alu_res = a + b;
                6'h22:   alu_res = a - b;
                6'h24:   alu_res = a & b;
                6'h25:   alu_res = a | b;
                6'h27:   alu_res = ~(a | b);
                6'h2A:   alu_res = {31'b0, $signed(a) < $signed(b)};
                6'h00:   alu_res = b << shamt;
                6'h02:   alu_res = b >> shamt;
                default: alu_res = 32'h0;
            endcase
        end else begin
            case (opcode)
                OP_ADDI, OP_LW, OP_SW: alu_res = a + sext;
                OP_SLTI: alu_res = {31'b0, $signed(a) < $signed(sext)};
                OP_ANDI: alu_res = a & zext;
                OP_ORI:  alu_res = a | zext;
                OP_LUI:  alu_res = {imm, 16'h0000};
                default: alu_res = 32'h0;
            endcase
        end
    end

    always_comb begin
        taken   = ((opcode == OP_BEQ) && (a == b)) || ((opcode == OP_BNE) && (a != b));
        wb_dst  = (opcode == OP_R) ? rd : rt;
        wb_data = (opcode == OP_LW) ? mdr : alu_out;
    end

    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            st          <= S_FETCH;
            pc          <= RESET_PC;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            illegal     <= 1'b0;
            instr_count <= 32'h0;
            ir          <= 32'h0;
            a           <= 32'h0;
            b           <= 32'h0;
            alu_out     <= 32'h0;
            mdr         <= 32'h0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else begin
            case (st)
                S_FETCH: begin
                    // An outstanding request completes even with cpu_en low.
                    if (mem_req) begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            ir      <= mem_rdata;
                            pc      <= pc + 32'd4;
                            st      <= S_DECODE;
                        end
                    end else if (cpu_en) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                S_DECODE: if (cpu_en) begin
                    a <= rf[rs];
                    b <= rf[rt];
                    if (legal) st <= S_EXEC;
                    else begin
                        st      <= S_ERR;
                        illegal <= 1'b1;
                    end
                end
                S_EXEC: if (cpu_en) begin
                    case (opcode)
                        OP_LW, OP_SW: begin
                            alu_out <= alu_res;
                            st      <= S_MEM;
                        end
                        OP_BEQ, OP_BNE: begin
                            if (taken) pc <= pc + {sext[29:0], 2'b00};
                            st          <= S_FETCH;
                            instr_count <= instr_count + 32'd1;
                        end
                        OP_J, OP_JAL: begin
                            pc <= {pc[31:28], target, 2'b00};
                            if (opcode == OP_JAL && LINK_REG != 5'd0) rf[LINK_REG] <= pc;
                            st          <= S_FETCH;
                            instr_count <= instr_count + 32'd1;
                        end
                        default: begin
                            alu_out <= alu_res;
                            st      <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_req) begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            if (opcode == OP_LW) begin
                                mdr <= mem_rdata;
                                st  <= S_WB;
                            end else begin
                                st          <= S_FETCH;
                                instr_count <= instr_count + 32'd1;
                            end
                        end
                    end else if (cpu_en) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (opcode == OP_SW);
                        mem_addr  <= {alu_out[31:2], 2'b00};
                        mem_wdata <= b;
                    end
                end
                S_WB: if (cpu_en) begin
                    if (wb_dst != 5'd0) rf[wb_dst] <= wb_data;
                    st          <= S_FETCH;
                    instr_count <= instr_count + 32'd1;
                end
                S_ERR: begin
                    illegal <= 1'b1;
                    mem_req <= 1'b0;
                end
                default: st <= S_FETCH;
            endcase
        end
    end
endmodule
